// File: rtl/mutex_pkg.sv
// -----------------------------------------------------------------------------
// mutex_pkg
// Shared definitions for the round-robin mutex arbiter:
//   - state_e  : arbiter FSM states (IDLE, GRANT, GAP)
//   - width_of : index/counter width helper that never returns zero, so that
//                degenerate sizes (e.g. a counter that only ever holds 0)
//                still produce a legal one-bit vector.
// -----------------------------------------------------------------------------
package mutex_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // nobody holds the mutex
        GRANT = 2'd1,   // val[owner] is high
        GAP   = 2'd2    // one dead cycle between two tenures
    } state_e;

    // Bits needed to encode values 0..n-1, at least one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage : mutex_pkg

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority encoder. Returns the first set bit of
// eligible_i found when scanning upward from start_i and wrapping past N-1
// back to 0.
//
// Ports:
//   eligible_i [N-1:0] : candidate vector
//   start_i    [W-1:0] : index where the scan begins (highest priority)
//   found_o            : at least one candidate is set
//   index_o    [W-1:0] : winning index (don't care when found_o = 0)
// -----------------------------------------------------------------------------
module rr_pick
    import mutex_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = width_of(N)
) (
    input  logic [N-1:0] eligible_i,
    input  logic [W-1:0] start_i,
    output logic         found_o,
    output logic [W-1:0] index_o
);

    logic         found_hi;
    logic [W-1:0] index_hi;
    logic [W-1:0] index_lo;

    // Two comparisons replace the usual rotate: the lowest candidate at or
    // above start_i wins; failing that, the lowest candidate overall (the
    // wrapped part of the scan). Scanning downward lets the lowest index
    // overwrite any higher one.
    // NOTE: every variable assigned in always_comb gets a default on entry,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        found_hi = 1'b0;
        index_hi = '0;
        index_lo = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (eligible_i[i]) begin
                index_lo = W'(i);
                if (W'(i) >= start_i) begin
                    index_hi = W'(i);
                    found_hi = 1'b1;
                end
            end
        end
    end

    assign found_o = |eligible_i;
    assign index_o = found_hi ? index_hi : index_lo;

endmodule : rr_pick

// File: rtl/mutex_rr.sv
// -----------------------------------------------------------------------------
// mutex_rr
// Round-robin mutex arbiter with bounded tenure. Requesters raise a level
// request and hold it for as long as they need the resource. The grant is
// registered and one-hot. Every release is followed by one dead (GAP) cycle.
// A grantee that overstays HOLD_MAX cycles while someone else waits is
// forcibly released. It is then masked until it drops its request, so it
// cannot immediately grab the resource back.
//
// Parameters:
//   NREQ     : number of requesters (2..8)
//   HOLD_MAX : tenure limit in cycles when others wait (0 = unlimited)
//
// Ports:
//   clk            : clock, rising edge
//   srst           : synchronous active-high reset
//   req   [NREQ-1:0] : level requests
//   val   [NREQ-1:0] : registered one-hot grant, zero when free
//   owner          : index of the grantee, valid while busy
//   busy           : some val bit is high
//   preempt        : one-cycle pulse in the cycle a forced release is decided
// -----------------------------------------------------------------------------
module mutex_rr
    import mutex_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned HOLD_MAX = 256
) (
    input  logic                        clk,
    input  logic                        srst,
    input  logic [NREQ-1:0]             req,
    output logic [NREQ-1:0]             val,
    output logic [width_of(NREQ)-1:0]   owner,
    output logic                        busy,
    output logic                        preempt
);

    localparam int unsigned OW = width_of(NREQ);
    localparam int unsigned CW = width_of(HOLD_MAX + 1);

    localparam logic [OW-1:0] LAST_RST = OW'(NREQ - 1);
    localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);
    localparam logic [CW-1:0] HOLD_PRE = (HOLD_MAX == 0) ? '0 : CW'(HOLD_MAX - 1);

    state_e          state_q, state_d;
    logic [NREQ-1:0] val_q,   val_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   last_q,  last_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [NREQ-1:0] mask_q,  mask_d;

    logic [NREQ-1:0] eligible;
    logic [OW-1:0]   start_idx;
    logic            pick_found;
    logic [OW-1:0]   pick_idx;
    logic            others_wait;
    logic            hold_hit;
    logic            preempt_c;

    // A requester masked by a forced release stays out of arbitration until
    // it has dropped its request at least once.
    assign eligible = req & ~mask_q;

    // In GRANT val_q is exactly the owner's bit, so this is "any other
    // eligible requester".
    assign others_wait = |(eligible & ~val_q);

    // The limit is reached at count HOLD_MAX-1. The count saturates above
    // that, so a waiter arriving later still triggers the release at once.
    assign hold_hit = (HOLD_MAX != 0) && (cnt_q >= HOLD_PRE);

    assign start_idx = (last_q == LAST_RST) ? '0 : last_q + 1'b1;

    rr_pick #(
        .N (NREQ),
        .W (OW)
    ) u_pick (
        .eligible_i (eligible),
        .start_i    (start_idx),
        .found_o    (pick_found),
        .index_o    (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        val_d     = val_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        mask_d    = mask_q & req;   // mask bits clear when req is sampled low
        preempt_c = 1'b0;

        unique case (state_q)
            IDLE, GAP: begin
                val_d   = '0;
                state_d = IDLE;
                if (pick_found) begin
                    state_d         = GRANT;
                    val_d[pick_idx] = 1'b1;
                    owner_d         = pick_idx;
                    last_d          = pick_idx;
                    cnt_d           = '0;
                end
            end

            GRANT: begin
                if (!req[owner_q]) begin
                    state_d = GAP;
                    val_d   = '0;
                end else if (hold_hit && others_wait) begin
                    state_d         = GAP;
                    val_d           = '0;
                    preempt_c       = 1'b1;
                    mask_d[owner_q] = 1'b1;
                end else if (cnt_q != HOLD_LIM) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                val_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge regardless of order.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= IDLE;
            val_q   <= '0;
            owner_q <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
        end
    end

    assign val     = val_q;
    assign owner   = owner_q;
    assign busy    = |val_q;
    assign preempt = preempt_c & ~srst;

endmodule : mutex_rr
